retire_trace_buffer: RTL

- Downstream consumer of the multicycle core's retire interface: update pulse, PC, instruction, rd address and rd data.
- Captures each retire into a FIFO and drains records to a trace logger or debug port over a valid/ready handshake.
- On overflow, enters a drop mode with hysteresis, so the consumer sees one clean, flagged gap instead of scattered losses.
- Sits beside the core and data memory at the top level; it never back-pressures the core.

---
 rtl/retire_trace_pkg.sv | 29 ++
 rtl/retire_trace_buffer_fifo.sv | 53 +++++
 rtl/retire_trace_buffer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/retire_trace_pkg.sv
// Shared record and state types for the retire trace buffer.
// Optional memory-access fields are present when RETIRE_TRACE_MEM_EN is defined.
package retire_trace_pkg;

   localparam int TRC_XLEN  = 32;
   localparam int TRC_SEQ_W = 16;
   localparam int TRC_DEPTH = 16;
   localparam int PTR_W     = $clog2(TRC_DEPTH);

   typedef enum logic {
      NORMAL = 1'b0,
      DROP   = 1'b1
   } trace_state_e;

   typedef struct packed {
      logic [TRC_XLEN-1:0]  pc;
      logic [TRC_XLEN-1:0]  instr;
      logic [4:0]           rd;
      logic [TRC_XLEN-1:0]  data;
      logic [TRC_SEQ_W-1:0] seq;
      logic                 gap;
`ifdef RETIRE_TRACE_MEM_EN
      logic                 mem_wrt;
      logic [TRC_XLEN-1:0]  mem_addr;
      logic [TRC_XLEN-1:0]  mem_data;
`endif
   } trace_rec_t;

endpackage

// File: rtl/retire_trace_buffer_fifo.sv
// Generic synchronous FIFO of trace records; occupancy-based full/empty and
// push+pop in one cycle at any occupancy, including full.
module trace_fifo
   import retire_trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  trace_rec_t             wr_data_i,
   output trace_rec_t             rd_data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   trace_rec_t     mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           do_push;
   logic           do_pop;

   assign full_o    = (count_o == CW'(DEPTH));
   assign empty_o   = (count_o == '0);
   assign do_pop    = pop_i & ~empty_o;
   assign do_push   = push_i & (~full_o | do_pop);
   assign rd_data_o = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count_o <= count_o + CW'(do_push) - CW'(do_pop);
      end
   end

   // NOTE: storage is not reset; the count gates every use, so stale slots are never observed.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= wr_data_i;
   end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: FIFO of retire records with a hysteretic drop mode.
// Define RETIRE_TRACE_MEM_EN to capture memory-store fields with each record.
module retire_trace_buffer
   import retire_trace_pkg::*;
#(
   parameter int XLEN  = TRC_XLEN,
   parameter int DEPTH = 16,
   parameter int SEQ_W = TRC_SEQ_W
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   update_i,
   input  logic [XLEN-1:0]        pc_i,
   input  logic [XLEN-1:0]        instr_i,
   input  logic [4:0]             reg_addr_i,
   input  logic [XLEN-1:0]        reg_data_i,
`ifdef RETIRE_TRACE_MEM_EN
   input  logic [XLEN-1:0]        mem_addr_i,
   input  logic [XLEN-1:0]        mem_data_i,
   input  logic                   mem_wrt_i,
   output logic [XLEN-1:0]        trace_mem_addr_o,
   output logic [XLEN-1:0]        trace_mem_data_o,
   output logic                   trace_mem_wrt_o,
`endif
   output logic                   trace_valid_o,
   input  logic                   trace_ready_i,
   output logic [XLEN-1:0]        trace_pc_o,
   output logic [XLEN-1:0]        trace_instr_o,
   output logic [XLEN-1:0]        trace_data_o,
   output logic [4:0]             trace_rd_o,
   output logic [SEQ_W-1:0]       trace_seq_o,
   output logic                   trace_gap_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic [SEQ_W-1:0]       drop_cnt_o,
   output logic                   dropping_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] HALF = CW'(DEPTH / 2);

   trace_state_e   state, state_next;
   trace_rec_t     wr_rec, head_rec, held_rec, out_rec;
   logic [CW-1:0]  count_after_pop;
   logic [SEQ_W-1:0] seq;
   logic           full, empty, pop, push, drop, gap_pending;

   assign pop             = ~empty & trace_ready_i;
   assign count_after_pop = count_o - CW'(pop);

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_next = state;
      push       = 1'b0;
      drop       = 1'b0;
      if (!flush_i) begin
         case (state)
            NORMAL: if (update_i) begin
               if (!full || pop) begin
                  push = 1'b1;
               end else begin
                  drop       = 1'b1;
                  state_next = DROP;
               end
            end
            DROP: begin
               drop = update_i;
               if (count_after_pop <= HALF) state_next = NORMAL;
            end
            default: state_next = NORMAL;
         endcase
      end else begin
         state_next = NORMAL;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= NORMAL;
      else       state <= state_next;
   end

   // seq counts every retire, stored or not; flush leaves it alone.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         seq         <= '0;
         drop_cnt_o  <= '0;
         gap_pending <= 1'b0;
      end else begin
         if (update_i) seq <= seq + 1'b1;
         if (flush_i) begin
            drop_cnt_o  <= '0;
            gap_pending <= 1'b0;
         end else if (drop) begin
            gap_pending <= 1'b1;
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
         end else if (push) begin
            gap_pending <= 1'b0;
         end
      end
   end

`ifdef RETIRE_TRACE_MEM_EN
   logic            side_wrt;
   logic [XLEN-1:0] side_addr, side_data;

   // Holds the latest store since the previous retire; consumed by the next retire.
   always_ff @(posedge clk_i) begin
      if (rst_i || update_i) begin
         side_wrt  <= 1'b0;
         side_addr <= '0;
         side_data <= '0;
      end else if (mem_wrt_i) begin
         side_wrt  <= 1'b1;
         side_addr <= mem_addr_i;
         side_data <= mem_data_i;
      end
   end
`endif

   always_comb begin
      wr_rec       = '0;
      wr_rec.pc    = pc_i;
      wr_rec.instr = instr_i;
      wr_rec.rd    = reg_addr_i;
      wr_rec.data  = reg_data_i;
      wr_rec.seq   = seq;
      wr_rec.gap   = gap_pending;
`ifdef RETIRE_TRACE_MEM_EN
      wr_rec.mem_wrt  = mem_wrt_i | side_wrt;
      wr_rec.mem_addr = mem_wrt_i ? mem_addr_i : side_addr;
      wr_rec.mem_data = mem_wrt_i ? mem_data_i : side_data;
`endif
   end

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush_i   (flush_i),
      .push_i    (push),
      .pop_i     (pop),
      .wr_data_i (wr_rec),
      .rd_data_o (head_rec),
      .count_o   (count_o),
      .full_o    (full),
      .empty_o   (empty)
   );

   // Keeps the last presented head so fields hold steady while empty.
   always_ff @(posedge clk_i) begin
      if (rst_i)       held_rec <= '0;
      else if (!empty) held_rec <= head_rec;
   end

   assign out_rec       = empty ? held_rec : head_rec;
   assign trace_valid_o = ~empty;
   assign trace_pc_o    = out_rec.pc;
   assign trace_instr_o = out_rec.instr;
   assign trace_data_o  = out_rec.data;
   assign trace_rd_o    = out_rec.rd;
   assign trace_seq_o   = out_rec.seq;
   assign trace_gap_o   = out_rec.gap;
   assign dropping_o    = (state == DROP);
`ifdef RETIRE_TRACE_MEM_EN
   assign trace_mem_addr_o = out_rec.mem_addr;
   assign trace_mem_data_o = out_rec.mem_data;
   assign trace_mem_wrt_o  = out_rec.mem_wrt;
`endif

endmodule
